// File: rtl/rr_arb9_pkg.sv
// ============================================================================
// rr_arb9_pkg
// Shared constants and helpers for the nine-requester round-robin arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arb9_pkg;

  localparam int RR_NREQ = 9;

  // Arbiter state encodings
  localparam logic [0:0] RR_IDLE = 1'b0;
  localparam logic [0:0] RR_LOCK = 1'b1;

  // Pointer value after reset: search starts at requester 0
  localparam logic [3:0] RR_PTR_RST = 4'd8;

  // Reduce an index in the range 0..17 to 0..8 (requester ring wrap)
  function automatic logic [3:0] rr_wrap(input logic [4:0] v);
    return (v >= 5'd9) ? 4'(v - 5'd9) : v[3:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb9_mux9.sv
// ============================================================================
// mux9
// One-hot 9:1 AND-OR data mux. An all-zero select yields all-zero data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux9
  import rr_arb9_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic [RR_NREQ*DW-1:0] data_in,
  input  logic [RR_NREQ-1:0]    sel,
  output logic [DW-1:0]         data_out
);

  logic [DW-1:0] term [RR_NREQ];

  for (genvar i = 0; i < RR_NREQ; i++) begin : g_term
    assign term[i] = data_in[i*DW +: DW] & {DW{sel[i]}};
  end

  // OR together the gated requester words
  always_comb begin
    data_out = '0;
    for (int i = 0; i < RR_NREQ; i++) begin
      data_out = data_out | term[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arb9.sv
// ============================================================================
// rr_arb9
// Nine-requester packet-locked round-robin arbiter feeding a registered
// valid/ready output channel through a one-hot 9:1 mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb9
  import rr_arb9_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RR_NREQ-1:0]    req_in,
  input  logic [RR_NREQ-1:0]    last_in,
  input  logic [RR_NREQ*DW-1:0] data_in,
  output logic [RR_NREQ-1:0]    ready_out,
  output logic [RR_NREQ-1:0]    grant,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  logic [0:0]         state;
  logic [3:0]         ptr;
  logic [RR_NREQ-1:0] rot;
  logic [RR_NREQ-1:0] pick;
  logic [RR_NREQ-1:0] win;
  logic [3:0]         gnt_idx;
  logic [RR_NREQ-1:0] xfer_vec;
  logic               xfer;
  logic               xfer_last;
  logic               out_free;
  logic [DW-1:0]      mux_data;

  // Round-robin pick: rotate so ptr+1 sits at bit 0, take lowest set bit, rotate back
  always_comb begin
    rot = '0;
    win = '0;
    for (int j = 0; j < RR_NREQ; j++) begin
      rot[j] = req_in[rr_wrap(5'(j) + {1'b0, ptr} + 5'd1)];
    end
    pick = rot & (~rot + 9'd1);
    for (int j = 0; j < RR_NREQ; j++) begin
      win[rr_wrap(5'(j) + {1'b0, ptr} + 5'd1)] = pick[j];
    end
  end

  // Binary index of the current grant, used to update ptr at packet end
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < RR_NREQ; i++) begin
      if (grant[i]) gnt_idx = 4'(i);
    end
  end

  // Accept only when the output register is empty or draining this cycle
  assign out_free  = !out_valid || out_ready;
  assign ready_out = (!reset && state == RR_LOCK) ? (grant & {RR_NREQ{out_free}}) : '0;
  assign xfer_vec  = req_in & ready_out;
  assign xfer      = |xfer_vec;
  assign xfer_last = |(xfer_vec & last_in);

  mux9 #(.DW(DW)) u_mux9 (
    .data_in  (data_in),
    .sel      (grant),
    .data_out (mux_data)
  );

  // Arbitration FSM: grant held from arbitration until the last beat transfers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RR_IDLE;
      grant <= '0;
      ptr   <= RR_PTR_RST;
    end else begin
      case (state)
        RR_IDLE: begin
          if (|req_in) begin
            grant <= win;
            state <= RR_LOCK;
          end
        end
        RR_LOCK: begin
          if (xfer && xfer_last) begin
            grant <= '0;
            ptr   <= gnt_idx;
            state <= RR_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= RR_IDLE;
        end
      endcase
    end
  end

  // Output pipeline register: load on transfer, otherwise empty when drained
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= xfer_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arb9.sv
// ============================================================================
// tb_rr_arb9
// Directed self-checking bench for rr_arb9 (DW=32).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arb9;
  import rr_arb9_pkg::*;

  localparam int DW = 32;

  logic              clk;
  logic              reset;
  logic [8:0]        req_in;
  logic [8:0]        last_in;
  logic [9*DW-1:0]   data_in;
  logic [8:0]        ready_out;
  logic [8:0]        grant;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_ready;

  int tests;
  int fails;

  rr_arb9 #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .last_in   (last_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dflt(input int i);
    return 32'hD000_0000 + 32'(i) * 32'h11;
  endfunction

  task automatic set_default_data();
    for (int i = 0; i < 9; i++) data_in[i*DW +: DW] = dflt(i);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_in = '0;
    last_in = '0;
    #1;
    chk("ready_in_reset", 64'(ready_out), 64'h0);
    tick();
    tick();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_last", 64'(out_last), 64'h0);
    chk("rst_ptr", 64'(dut.ptr), 64'd8);
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    int rcv;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    req_in = '0;
    last_in = '0;
    out_ready = 1'b1;
    set_default_data();
    tick();
    do_reset();

    // ---- Reset priority: all request, single-beat packets ----
    req_in  = 9'h1FF;
    last_in = 9'h1FF;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rot_grant", 64'(grant), 64'(9'h001 << (k % 9)));
      #1;
      chk("rot_ready", 64'(ready_out), 64'(9'h001 << (k % 9)));
      tick();
      chk("rot_grant_idle", 64'(grant), 64'h0);
      chk("rot_valid", 64'(out_valid), 64'h1);
      chk("rot_data", 64'(out_data), 64'(dflt(k % 9)));
      chk("rot_last", 64'(out_last), 64'h1);
    end
    req_in  = '0;
    last_in = '0;
    tick();
    chk("rot_drain", 64'(out_valid), 64'h0);

    // ---- Packet lock: requester 3 (4 beats), requester 5 waiting ----
    req_in = 9'h028;
    tick();
    chk("lock_grant0", 64'(grant), 64'h008);
    for (int b = 0; b < 4; b++) begin
      data_in[3*DW +: DW] = 32'h0000_3000 + 32'(b);
      last_in = (b == 3) ? 9'h008 : 9'h000;
      #1;
      chk("lock_grant", 64'(grant), 64'h008);
      chk("lock_ready", 64'(ready_out), 64'h008);
      tick();
      chk("lock_data", 64'(out_data), 64'(32'h0000_3000 + 32'(b)));
    end
    chk("lock_end_grant", 64'(grant), 64'h0);
    chk("lock_ptr", 64'(dut.ptr), 64'd3);
    last_in = '0;
    req_in = 9'h020;
    tick();
    chk("lock_next_grant", 64'(grant), 64'h020);

    // ---- Backpressure on requester 5, counting pattern, 8 beats ----
    cnt = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 7);
      req_in = (cnt < 8) ? 9'h020 : 9'h000;
      data_in[5*DW +: DW] = 32'hC000_0000 + 32'(cnt);
      last_in = (cnt == 7) ? 9'h020 : 9'h000;
      #1;
      if (!out_ready) begin
        chk("bp_ready", 64'(ready_out), 64'h0);
        chk("bp_valid", 64'(out_valid), 64'h1);
        chk("bp_hold", 64'(out_data), 64'(32'hC000_0000 + 32'(rcv)));
      end
      if (out_valid && out_ready) begin
        chk("bp_data", 64'(out_data), 64'(32'hC000_0000 + 32'(rcv)));
        rcv++;
      end
      if (req_in[5] && ready_out[5]) cnt++;
      tick();
    end
    chk("bp_sent", 64'(cnt), 64'd8);
    chk("bp_rcvd", 64'(rcv), 64'd8);
    out_ready = 1'b1;
    req_in = '0;
    last_in = '0;
    tick();
    chk("bp_ptr", 64'(dut.ptr), 64'd5);

    // ---- Requester stall: 7 granted, drops request, 0 waits ----
    req_in = 9'h081;
    tick();
    chk("stall_grant0", 64'(grant), 64'h080);
    data_in[7*DW +: DW] = 32'h0000_7000;
    tick();
    chk("stall_beat0", 64'(out_data), 64'h7000);
    req_in = 9'h001;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_grant", 64'(grant), 64'h080);
      chk("stall_r0", 64'(ready_out[0]), 64'h0);
      tick();
    end
    chk("stall_data", 64'(out_data), 64'h7000);
    chk("stall_drained", 64'(out_valid), 64'h0);
    req_in = 9'h081;
    last_in = 9'h080;
    data_in[7*DW +: DW] = 32'h0000_7001;
    tick();
    chk("stall_last_data", 64'(out_data), 64'h7001);
    chk("stall_last_flag", 64'(out_last), 64'h1);
    chk("stall_end_grant", 64'(grant), 64'h0);

    // ---- Wrap-around: ptr=8, requesters 8 and 0 ----
    set_default_data();
    do_reset();
    req_in = 9'h101;
    last_in = 9'h1FF;
    tick();
    chk("wrap_first", 64'(grant), 64'h001);
    tick();
    chk("wrap_data0", 64'(out_data), 64'(dflt(0)));
    tick();
    chk("wrap_second", 64'(grant), 64'h100);
    tick();
    chk("wrap_data8", 64'(out_data), 64'(dflt(8)));

    // ---- Mid-packet reset during requester 4 packet ----
    req_in = 9'h010;
    last_in = 9'h000;
    tick();
    chk("mr_grant", 64'(grant), 64'h010);
    tick();
    chk("mr_beat1", 64'(out_data), 64'(dflt(4)));
    reset = 1'b1;
    #1;
    chk("mr_ready_rst", 64'(ready_out), 64'h0);
    tick();
    reset = 1'b0;
    req_in = 9'h011;
    chk("mr_grant0", 64'(grant), 64'h0);
    chk("mr_valid0", 64'(out_valid), 64'h0);
    chk("mr_state", 64'(dut.state), 64'(RR_IDLE));
    tick();
    chk("mr_rearb", 64'(grant), 64'h001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_arb9.md
# rr_arb9

Nine-requester round-robin packet arbiter that sequences the shared one-hot 9:1 data mux. It grants the mux to one requester at a time and holds the grant until that requester's last beat. Accepted beats go through a single pipeline register onto one valid/ready output channel. It sits in front of any shared egress path: link transmit, memory port, or register bus.

## Interface
- `DW`, default 1: data width per requester and of the output.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req_in`  input  9  per-requester beat valid; bit i belongs to requester i.
- `last_in`  input  9  per-requester last-beat-of-packet flag; sampled only with a transfer.
- `data_in`  input  9*DW  packed requester data; requester i occupies bits [i*DW +: DW].
- `ready_out`  output  9  per-requester accept; at most one bit set.
- `grant`  output  9  registered one-hot grant, or all-zero; drives the mux selects.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  DW  registered selected data.
- `out_last`  output  1  registered last flag of the beat in `out_data`.
- `out_ready`  input  1  downstream accept.

## Operation
- States: IDLE, LOCK.
- IDLE: `grant`=0 and `ready_out`=0. If any `req_in` bit is set, the round-robin winner is loaded into `grant` and the state moves to LOCK at the next edge.
- Round-robin search: start at `ptr`+1 and ascend, wrapping 8→0; the first set `req_in` bit wins. `ptr` holds the index of the last requester whose packet completed.
- LOCK: `ready_out[i]` = `grant[i]` & (!`out_valid` | `out_ready`). A transfer occurs when `req_in[i]` & `ready_out[i]`.
- On a transfer, the output register loads mux(`data_in`, `grant`) and `last_in[i]`, and `out_valid` is set to 1.
- A transfer with `last_in[i]`=1 ends the packet: at the next edge the state becomes IDLE, `grant` becomes 0, and `ptr` becomes i.
- The grant is packet-locked. If the granted requester deasserts `req_in` mid-packet, the grant is held indefinitely. Other requesters are never served mid-packet and there is no timeout.
- Output register: `out_valid` clears when `out_ready`=1 and no new transfer occurs in that cycle. A simultaneous drain and load keeps `out_valid`=1. `out_data` and `out_last` hold their values while `out_valid`=1 and `out_ready`=0.
- Data mux: the AND-OR one-hot mux selected by `grant`. Width is exactly DW and there is no arithmetic on data.
- Reset, including mid-packet: state becomes IDLE and the packet in flight is abandoned. The following are cleared: `grant`=0, `ptr`=8 (requester 0 has first priority), `out_valid`=0, `out_data`=0, `out_last`=0. `ready_out`=0 while `reset` is high.

## Timing
- Arbitration latency: a request in IDLE at cycle N gives `grant` at N+1. The first beat can transfer at N+1, and `out_valid` rises at N+2.
- Packet gap: a last beat accepted at cycle M gives IDLE at M+1 and the next grant at M+2. This is one bubble cycle per packet boundary.
- Throughput inside a packet: one beat per cycle while `out_ready`=1.
- Backpressure: `ready_out` is combinational from `grant`, `out_valid` and `out_ready`. There is no combinational path from `req_in` to `ready_out`.
- Single-beat packets (`last_in`=1 on the first beat) are legal and take a grant for exactly one transfer cycle.
- Requests asserted during LOCK are only evaluated in IDLE. They see the updated `ptr`.

## Structure
- Shared package or include:
  - `RR_NREQ`=9.
  - State encodings `RR_IDLE` and `RR_LOCK`.
  - Reset pointer constant `RR_PTR_RST`=8.
- Sub-module: instantiate the existing `mux9` one-hot mux with `sel`=`grant`. It is the only sub-module.
- Round-robin priority logic is local combinational logic in `rr_arb9`. It is implemented as a rotate-by-ptr, a fixed-priority pick, and a rotate-back.

## Test plan
- Reset priority: after reset, `req_in`=9'h1FF with all `last_in`=1. Grants must rotate 0,1,2,…,8,0, one grant every 2 cycles, with `out_data` equal to each requester's data.
- Packet lock: requester 3 sends a 4-beat packet while requester 5 requests throughout. `grant`=9'h008 must hold for all 4 beats. `grant`=9'h020 is required 2 cycles after beat 4 is accepted, and `ptr` must be 3.
- Backpressure: `out_ready`=0 for 5 cycles mid-packet. Required: `ready_out`=0, `out_valid`=1, and `out_data` stable. When `out_ready` returns to 1, no beats are lost or duplicated, checked on a DW=32 counting pattern.
- Requester stall: the granted requester 7 drops `req_in` for 3 cycles mid-packet while requester 0 requests. `grant` must stay 9'h080 and no transfer may occur for requester 0.
- Wrap-around: `ptr`=8 and requests only on requesters 8 and 0. Requester 0 must win first, then requester 8.
- Mid-packet reset: pulse `reset` during beat 2 of a packet from requester 4. The next cycle must show `grant`=0, `out_valid`=0, and state IDLE. The following arbitration with `req_in`=9'h011 must grant requester 0.
